// File: rtl/arch_defs_pkg.sv
// Shared widths, opcode/microstep encodings and the control word for the SAP computer.
// Optional build macro SAP_TRACE_EN is consumed by the top level only.
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_JN  = 4'h9,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        RESET,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6
    } microstep_t;

    typedef enum logic [1:0] {
        A_SRC_MEM,
        A_SRC_IMM,
        A_SRC_ALU
    } a_src_t;

    typedef struct packed {
        logic   mar_from_pc;
        logic   mar_from_ir;
        logic   ir_load;
        logic   pc_inc;
        logic   pc_load;
        logic   a_load;
        a_src_t a_src;
        logic   b_load;
        logic   o_load;
        logic   ram_write;
        logic   alu_sub;
        logic   flags_zn_load;
        logic   flags_c_load;
        logic   halt_set;
    } control_word_t;

    localparam control_word_t CW_IDLE = '0;

    function automatic microstep_t next_microstep(input microstep_t step);
        case (step)
            RESET:   return T0;
            T0:      return T1;
            T1:      return T2;
            T2:      return T3;
            T3:      return T4;
            T4:      return T5;
            T5:      return T6;
            default: return T0;
        endcase
    endfunction

endpackage

// File: rtl/sap_computer_control_unit.sv
// Fixed 7-step sequencer plus microcode decode; once halted, every control line stays idle.
module sap_computer_control_unit
    import arch_defs_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    opcode,
    input  logic          flag_zero,
    input  logic          flag_carry,
    input  logic          flag_negative,
    output control_word_t cw,
    output logic          halt
);

    microstep_t step;
    microstep_t step_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            step <= RESET;
            halt <= 1'b0;
        end else begin
            if (!halt) begin
                step <= step_next;
            end
            if (cw.halt_set) begin
                halt <= 1'b1;
            end
        end
    end

    always_comb begin
        step_next = next_microstep(step);
    end

    always_comb begin
        cw = CW_IDLE;
        if (!halt) begin
            case (step)
                T0: cw.mar_from_pc = 1'b1;
                T1: begin
                    cw.ir_load = 1'b1;
                    cw.pc_inc  = 1'b1;
                end
                T2: begin
                    case (opcode_t'(opcode))
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: cw.mar_from_ir = 1'b1;
                        OP_LDI: begin
                            cw.a_load        = 1'b1;
                            cw.a_src         = A_SRC_IMM;
                            cw.flags_zn_load = 1'b1;
                        end
                        OP_JMP: cw.pc_load = 1'b1;
                        OP_JC:  cw.pc_load = flag_carry;
                        OP_JZ:  cw.pc_load = flag_zero;
                        OP_JN:  cw.pc_load = flag_negative;
                        OP_OUT: cw.o_load  = 1'b1;
                        OP_HLT: cw.halt_set = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode_t'(opcode))
                        OP_LDA: begin
                            cw.a_load        = 1'b1;
                            cw.a_src         = A_SRC_MEM;
                            cw.flags_zn_load = 1'b1;
                        end
                        OP_ADD, OP_SUB: cw.b_load    = 1'b1;
                        OP_STA:         cw.ram_write = 1'b1;
                        default: ;
                    endcase
                end
                T4: begin
                    // The ALU result lands in A one step after B is fetched.
                    if (opcode_t'(opcode) == OP_ADD || opcode_t'(opcode) == OP_SUB) begin
                        cw.a_load        = 1'b1;
                        cw.a_src         = A_SRC_ALU;
                        cw.alu_sub       = (opcode_t'(opcode) == OP_SUB);
                        cw.flags_zn_load = 1'b1;
                        cw.flags_c_load  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sap_computer_program_counter.sv
// Program counter: wraps naturally at 2**ADDR_WIDTH; a jump load wins over increment.
module sap_computer_program_counter
    import arch_defs_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    output logic [ADDR_WIDTH-1:0] counter_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_out <= '0;
        end else if (load) begin
            counter_out <= load_value;
        end else if (inc) begin
            counter_out <= counter_out + 1'b1;
        end
    end

endmodule

// File: rtl/sap_computer_ram.sv
// 16x8 program/data RAM: combinational read, synchronous write; contents survive reset.
module sap_computer_ram
    import arch_defs_pkg::*;
(
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[addr] <= write_data;
        end
    end

    assign read_data = mem[addr];

    // Snapshot access to a single word for observers outside the datapath.
    task automatic dump(input logic [ADDR_WIDTH-1:0] word_addr,
                        output logic [DATA_WIDTH-1:0] word_data);
        word_data = mem[word_addr];
    endtask

endmodule

// File: rtl/sap_computer_register.sv
// Generic load-enabled register used for A, B, O, IR and MAR.
module sap_computer_register
    import arch_defs_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] latched_data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            latched_data <= '0;
        end else if (load) begin
            latched_data <= data_in;
        end
    end

endmodule

// File: rtl/sap_computer.sv
// SAP-1.5 style computer top: datapath registers, ALU, flags and control unit.
// Define SAP_TRACE_EN to print a state line at every T6 edge and on halt.
module sap_computer
    import arch_defs_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] out_val,
    output logic                  flag_zero_o,
    output logic                  flag_carry_o,
    output logic                  flag_negative_o
);

    control_word_t         cw;
    logic                  halt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] mar;
    logic [ADDR_WIDTH-1:0] mar_in;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [DATA_WIDTH:0]   alu_full;
    logic                  flag_zero;
    logic                  flag_carry;
    logic                  flag_negative;

    sap_computer_control_unit u_control_unit (
        .clk           (clk),
        .reset         (reset),
        .opcode        (ir[7:4]),
        .flag_zero     (flag_zero),
        .flag_carry    (flag_carry),
        .flag_negative (flag_negative),
        .cw            (cw),
        .halt          (halt)
    );

    sap_computer_program_counter u_program_counter (
        .clk         (clk),
        .reset       (reset),
        .inc         (cw.pc_inc),
        .load        (cw.pc_load),
        .load_value  (ir[3:0]),
        .counter_out (pc)
    );

    assign mar_in = cw.mar_from_pc ? pc : ir[3:0];

    sap_computer_register #(.WIDTH(ADDR_WIDTH)) u_register_mar (
        .clk          (clk),
        .reset        (reset),
        .load         (cw.mar_from_pc | cw.mar_from_ir),
        .data_in      (mar_in),
        .latched_data (mar)
    );

    sap_computer_ram u_ram (
        .clk        (clk),
        .write_en   (cw.ram_write),
        .addr       (mar),
        .write_data (a_reg),
        .read_data  (ram_data)
    );

    sap_computer_register #(.WIDTH(DATA_WIDTH)) u_register_ir (
        .clk          (clk),
        .reset        (reset),
        .load         (cw.ir_load),
        .data_in      (ram_data),
        .latched_data (ir)
    );

    sap_computer_register #(.WIDTH(DATA_WIDTH)) u_register_B (
        .clk          (clk),
        .reset        (reset),
        .load         (cw.b_load),
        .data_in      (ram_data),
        .latched_data (b_reg)
    );

    // Subtraction is A + ~B + 1, so the carry out reads as "no borrow".
    always_comb begin
        if (cw.alu_sub) begin
            alu_full = {1'b0, a_reg} + {1'b0, ~b_reg} + 9'd1;
        end else begin
            alu_full = {1'b0, a_reg} + {1'b0, b_reg};
        end
    end

    always_comb begin
        case (cw.a_src)
            A_SRC_IMM: a_in = {4'h0, ir[3:0]};
            A_SRC_ALU: a_in = alu_full[DATA_WIDTH-1:0];
            default:   a_in = ram_data;
        endcase
    end

    sap_computer_register #(.WIDTH(DATA_WIDTH)) u_register_A (
        .clk          (clk),
        .reset        (reset),
        .load         (cw.a_load),
        .data_in      (a_in),
        .latched_data (a_reg)
    );

    sap_computer_register #(.WIDTH(DATA_WIDTH)) u_register_o (
        .clk          (clk),
        .reset        (reset),
        .load         (cw.o_load),
        .data_in      (a_reg),
        .latched_data (out_val)
    );

    // Z and N track whatever value is being written into A; C only moves on ADD/SUB.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_zero     <= 1'b0;
            flag_carry    <= 1'b0;
            flag_negative <= 1'b0;
        end else begin
            if (cw.flags_zn_load) begin
                flag_zero     <= (a_in == '0);
                flag_negative <= a_in[DATA_WIDTH-1];
            end
            if (cw.flags_c_load) begin
                flag_carry <= alu_full[DATA_WIDTH];
            end
        end
    end

    assign flag_zero_o     = flag_zero;
    assign flag_carry_o    = flag_carry;
    assign flag_negative_o = flag_negative;

`ifdef SAP_TRACE_EN
    always @(posedge clk) begin
        if (!reset && !halt && u_control_unit.step == T6) begin
            $display("[SAP] t=%0t PC=%h IR=%h A=%h B=%h O=%h Z=%b C=%b N=%b",
                     $time, pc, ir, a_reg, b_reg, out_val,
                     flag_zero, flag_carry, flag_negative);
        end
        if (!reset && cw.halt_set) begin
            $display("[SAP] t=%0t halted at PC=%h", $time, pc);
        end
    end
`else
`endif

endmodule

// File: tb/tb_sap_computer.sv
// Self-checking bench: directed programs plus random programs against an instruction-level model.
module tb_sap_computer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] out_val;
    logic       flag_zero_o;
    logic       flag_carry_o;
    logic       flag_negative_o;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] prog      [16];
    logic [7:0] model_mem [16];
    logic [3:0] m_pc;
    logic [7:0] m_a, m_b, m_o;
    logic       m_z, m_c, m_n, m_halt;
    logic       first_instr;
    logic [7:0] mem_word;

    sap_computer dut (
        .clk             (clk),
        .reset           (reset),
        .out_val         (out_val),
        .flag_zero_o     (flag_zero_o),
        .flag_carry_o    (flag_carry_o),
        .flag_negative_o (flag_negative_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag);
        check_output({tag, ".A"}, dut.u_register_A.latched_data, m_a);
        check_output({tag, ".PC"}, {4'h0, dut.u_program_counter.counter_out}, {4'h0, m_pc});
        check_output({tag, ".O"}, dut.u_register_o.latched_data, m_o);
        check_output({tag, ".out_val"}, out_val, m_o);
        check_output({tag, ".flags"}, {5'b0, flag_negative_o, flag_carry_o, flag_zero_o},
                     {5'b0, m_n, m_c, m_z});
        check_output({tag, ".halt"}, {7'b0, dut.halt}, {7'b0, m_halt});
    endtask

    // Architectural model: one call executes one whole instruction.
    task automatic model_step();
        logic [7:0] instr;
        logic [3:0] opd;
        int         sum;
        if (m_halt) return;
        instr = model_mem[m_pc];
        opd   = instr[3:0];
        m_pc  = m_pc + 4'd1;
        case (instr[7:4])
            4'h1: begin m_a = model_mem[opd]; m_z = (m_a == 0); m_n = m_a[7]; end
            4'h2: begin
                m_b = model_mem[opd];
                sum = int'(m_a) + int'(m_b);
                m_c = (sum > 255);
                m_a = 8'(sum % 256);
                m_z = (m_a == 0); m_n = m_a[7];
            end
            4'h3: begin
                m_b = model_mem[opd];
                m_c = (m_a >= m_b);
                sum = int'(m_a) - int'(m_b) + 256;
                m_a = 8'(sum % 256);
                m_z = (m_a == 0); m_n = m_a[7];
            end
            4'h4: model_mem[opd] = m_a;
            4'h5: begin m_a = {4'h0, opd}; m_z = (m_a == 0); m_n = 1'b0; end
            4'h6: m_pc = opd;
            4'h7: if (m_c) m_pc = opd;
            4'h8: if (m_z) m_pc = opd;
            4'h9: if (m_n) m_pc = opd;
            4'hE: m_o = m_a;
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_pc = 4'h0; m_a = 8'h00; m_b = 8'h00; m_o = 8'h00;
        m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_halt = 1'b0;
    endtask

    // Hold reset, load the program into DUT RAM and model, then release.
    task automatic start_program(input string tag);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            dut.u_ram.mem[i] = prog[i];
            model_mem[i] = prog[i];
        end
        model_reset();
        check_state({tag, ".reset"});
        reset = 1'b0;
        first_instr = 1'b1;
    endtask

    task automatic apply_stimulus(input int n_instr, input string tag);
        for (int i = 0; i < n_instr; i++) begin
            repeat (first_instr ? 8 : 7) @(posedge clk);
            @(negedge clk);
            first_instr = 1'b0;
            model_step();
            check_state($sformatf("%s.i%0d", tag, i));
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    initial begin
        // JZ taken / not taken, OUTA, HLT and freeze.
        clear_prog();
        prog[0] = 8'h50; prog[1] = 8'h85; prog[5] = 8'h51;
        prog[6] = 8'h89; prog[7] = 8'hE0; prog[8] = 8'hF0;
        start_program("jz");
        apply_stimulus(1, "jz_ldi0");
        check_output("jz_first_A", dut.u_register_A.latched_data, 8'h00);
        check_output("jz_first_Z", {7'b0, flag_zero_o}, 8'h01);
        apply_stimulus(5, "jz");
        check_output("jz_halt_pc", {4'h0, dut.u_program_counter.counter_out}, 8'h09);
        check_output("jz_halt_O", out_val, 8'h01);
        apply_stimulus(3, "jz_frozen");

        // ADD with carry followed by a taken JC.
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2D; prog[2] = 8'h73; prog[3] = 8'hE0;
        prog[4] = 8'hF0; prog[13] = 8'h20; prog[14] = 8'hF0;
        start_program("add");
        apply_stimulus(2, "add");
        check_output("add_A", dut.u_register_A.latched_data, 8'h10);
        check_output("add_C", {7'b0, flag_carry_o}, 8'h01);
        apply_stimulus(3, "add_jc");

        // SUB to zero, then SUB with borrow.
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h3E; prog[2] = 8'h1E; prog[3] = 8'h3D;
        prog[4] = 8'hF0; prog[13] = 8'h06; prog[14] = 8'h05;
        start_program("sub");
        apply_stimulus(5, "sub");
        check_output("sub_borrow_A", dut.u_register_A.latched_data, 8'hFF);

        // STA/LDA round trip through the top RAM word.
        clear_prog();
        prog[0] = 8'h57; prog[1] = 8'h4F; prog[2] = 8'h50; prog[3] = 8'h1F;
        prog[4] = 8'hE0; prog[5] = 8'hF0;
        start_program("sta");
        apply_stimulus(6, "sta");
        dut.u_ram.dump(4'hF, mem_word);
        check_output("sta_mem15", mem_word, model_mem[15]);
        check_output("sta_mem15_const", mem_word, 8'h07);

        // Reset asserted during T3 of ADD aborts it; program restarts cleanly.
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2D; prog[2] = 8'h73; prog[3] = 8'hE0;
        prog[4] = 8'hF0; prog[13] = 8'h20; prog[14] = 8'hF0;
        start_program("midrst");
        apply_stimulus(1, "midrst_lda");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_state("midrst_abort");
        reset = 1'b0;
        first_instr = 1'b1;
        apply_stimulus(5, "midrst_rerun");

        // Random programs against the model.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
            start_program($sformatf("rnd%0d", r));
            apply_stimulus(12, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
